// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Fetches one instruction word at a time from instruction memory and holds it
// in an instruction register for decode. The next fetch address is chosen when
// the issued instruction leaves ISSUE. Priority is jr, then jump, then taken
// branch, then sequential.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   imem_req/addr     fetch request and address (address is always pc)
//   imem_ack/rdata    memory response; only honoured while fetching
//   stall             downstream hold of the issued instruction
//   br_taken, br_off  taken conditional branch; br_off is the sign-extended
//                     word offset
//   jump              J/JAL redirect using instr[25:0]
//   jr, jr_target     register-indirect redirect
//   pc, pc_plus4      address of the current instruction and its successor
//   instr, imm        instruction register and its low 16 bits
//   instr_valid       instr holds a valid instruction for decode
//   addr_err          sticky misaligned-target flag
//
// Configuration
//   IFU_ALIGN_CHK_EN  when defined, a misaligned next pc sets addr_err and parks
//                     the unit in HALT until reset. When undefined, the low two
//                     bits of the next pc are cleared and addr_err is tied to 0.
// -----------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_off,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [15:0] imm,
    output logic        instr_valid,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_target;

    // Outputs decode directly from the state register, so an asynchronous
    // reset drops imem_req and instr_valid in the same instant.
    assign imem_req    = (r_state == FETCH);
    assign instr_valid = (r_state == ISSUE);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instr       = r_instr;
    assign imm         = r_instr[15:0];

    // Redirect target, before any alignment handling.
    always_comb begin
        if (jr) begin
            w_target = jr_target;
        end else if (jump) begin
            w_target = {pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (br_taken) begin
            w_target = pc_plus4 + (br_off << 2);
        end else begin
            w_target = pc_plus4;
        end
    end

`ifdef IFU_ALIGN_CHK_EN
    logic r_addr_err;
    logic w_addr_err_nxt;
    logic w_misaligned;

    assign w_misaligned = |w_target[1:0];
    assign addr_err     = r_addr_err;
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
`ifdef IFU_ALIGN_CHK_EN
        w_addr_err_nxt = r_addr_err;
`endif
        unique case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
`ifdef IFU_ALIGN_CHK_EN
                    if (w_misaligned) begin
                        // pc keeps the faulting instruction's address for debug.
                        w_addr_err_nxt = 1'b1;
                        w_state_nxt    = HALT;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = FETCH;
                    end
`else
                    w_pc_nxt    = {w_target[31:2], 2'b00};
                    w_state_nxt = FETCH;
`endif
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
        end
    end

`ifdef IFU_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_addr_err_nxt;
        end
    end
`endif

endmodule
